// File: rtl/bcd_counter_chain_pkg.sv
// counter_pkg: shared BCD digit type and limits for bcd_counter_chain.
package counter_pkg;
    typedef logic [3:0] bcd_t;
    localparam bcd_t BCD_MAX    = 4'd9;
    localparam bcd_t BCD_MIN    = 4'd0;
    localparam int   MAX_DIGITS = 8;
endpackage

// File: rtl/bcd_counter_chain_if.sv
// bcd_counter_chain_if: control and count bus; dir exists only with COUNTER_DOWN_EN.
interface bcd_counter_chain_if #(parameter int DIGITS = 4);
    logic                enabled;
    logic                clear;
`ifdef COUNTER_DOWN_EN
    logic                dir;
`endif
    logic [4*DIGITS-1:0] digits;
    logic                step;
    logic                overflow;
`ifdef COUNTER_DOWN_EN
    modport master(output enabled, clear, dir, input digits, step, overflow);
    modport slave(input enabled, clear, dir, output digits, step, overflow);
`else
    modport master(output enabled, clear, input digits, step, overflow);
    modport slave(input enabled, clear, output digits, step, overflow);
`endif
endinterface

// File: rtl/bcd_counter_chain_digit.sv
// bcd_digit: one modulo-10 BCD digit register with up/down step and wrap flag.
module bcd_digit
    import counter_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_step,
    input  logic i_dir,
    input  logic i_clear,
    output bcd_t o_value,
    output logic o_wrap
);
    bcd_t r_value;
    bcd_t w_next;
    // Out-of-range values 10..15 recover to the direction's restart value.
    always_comb begin
        w_next = i_dir ? ((r_value == BCD_MIN || r_value > BCD_MAX) ? BCD_MAX : r_value - 4'd1)
                       : ((r_value >= BCD_MAX) ? BCD_MIN : r_value + 4'd1);
        o_wrap = r_value == (i_dir ? BCD_MIN : BCD_MAX);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       r_value <= BCD_MIN;
        else if (i_clear) r_value <= BCD_MIN;
        else if (i_step)  r_value <= w_next;
    end
    assign o_value = r_value;
endmodule

// File: rtl/bcd_counter_chain.sv
// bcd_counter_chain: prescaler feeding a cascade of DIGITS BCD digits with step/overflow pulses.
// Define COUNTER_DOWN_EN to add the dir input and down counting.
module bcd_counter_chain
    import counter_pkg::*;
#(
    parameter int PRESCALE = 500000,
    parameter int DIGITS   = 4
) (
    input logic clk,
    input logic rst_n,
    bcd_counter_chain_if.slave bus
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    logic [PW-1:0]       r_pre;
    logic                r_step;
    logic                r_overflow;
    logic                w_adv;
    logic                w_dir;
    logic [DIGITS:0]     w_carry;
    logic [DIGITS-1:0]   w_wrap;
    logic [4*DIGITS-1:0] w_digits;
`ifdef COUNTER_DOWN_EN
    assign w_dir = bus.dir;
`else
    assign w_dir = 1'b0;
`endif
    assign w_adv      = bus.enabled && (r_pre == PW'(PRESCALE - 1));
    assign w_carry[0] = w_adv;
    // The carry out of the top digit is the whole-chain wrap.
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_step  (w_carry[g]),
            .i_dir   (w_dir),
            .i_clear (bus.clear),
            .o_value (w_digits[4*g +: 4]),
            .o_wrap  (w_wrap[g])
        );
        assign w_carry[g+1] = w_carry[g] & w_wrap[g];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre      <= '0;
            r_step     <= 1'b0;
            r_overflow <= 1'b0;
        end else if (bus.clear) begin
            r_pre      <= '0;
            r_step     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_step     <= w_adv;
            r_overflow <= w_carry[DIGITS];
            if (bus.enabled) r_pre <= w_adv ? '0 : r_pre + 1'b1;
        end
    end
    assign bus.digits   = w_digits;
    assign bus.step     = r_step;
    assign bus.overflow = r_overflow;
endmodule
